// File: rtl/csr_pkg.sv
// Shared machine-mode CSR definitions for the trap controller.
// Contents:
//   - CSR addresses for mstatus, mtvec, mepc, mcause and mtval
//   - mstatus bit positions (MIE, MPIE, MPP)
//   - synchronous exception cause codes
//   - bit positions of the commit-stage event flags in the gated flag vector
//   - trap sequencer state encoding
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [4:0] CAUSE_INS_ADDR_MIS   = 5'd0;
  localparam logic [4:0] CAUSE_INS_ACC_FAULT  = 5'd1;
  localparam logic [4:0] CAUSE_ILL_INS        = 5'd2;
  localparam logic [4:0] CAUSE_EBREAK         = 5'd3;
  localparam logic [4:0] CAUSE_LD_ADDR_MIS    = 5'd4;
  localparam logic [4:0] CAUSE_LD_ACC_FAULT   = 5'd5;
  localparam logic [4:0] CAUSE_ST_ADDR_MIS    = 5'd6;
  localparam logic [4:0] CAUSE_ST_ACC_FAULT   = 5'd7;
  localparam logic [4:0] CAUSE_ECALL_M        = 5'd11;
  localparam logic [4:0] CAUSE_INS_PAGE_FAULT = 5'd12;
  localparam logic [4:0] CAUSE_LD_PAGE_FAULT  = 5'd13;
  localparam logic [4:0] CAUSE_ST_PAGE_FAULT  = 5'd15;

  // Positions of the exception flags (plus s_ret) in the valid-gated vector.
  localparam int EXC_INS_ADDR_MIS   = 0;
  localparam int EXC_INS_PAGE_FAULT = 1;
  localparam int EXC_INS_ACC_FAULT  = 2;
  localparam int EXC_ILL_INS        = 3;
  localparam int EXC_S_RET          = 4;
  localparam int EXC_ECALL          = 5;
  localparam int EXC_EBREAK         = 6;
  localparam int EXC_ST_ADDR_MIS    = 7;
  localparam int EXC_LD_ADDR_MIS    = 8;
  localparam int EXC_ST_PAGE_FAULT  = 9;
  localparam int EXC_LD_PAGE_FAULT  = 10;
  localparam int EXC_ST_ACC_FAULT   = 11;
  localparam int EXC_LD_ACC_FAULT   = 12;
  localparam int N_EXC              = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_EPC,
    ST_W_CAUSE,
    ST_W_TVAL,
    ST_W_STAT,
    ST_R_STAT,
    ST_REDIRECT
  } trap_state_e;

endpackage

// File: rtl/trap_prio_enc.sv
// Combinational priority encoder for commit-stage trap events.
// Ports:
//   int_acc, int_cause      accepted interrupt and its code (highest priority)
//   exc                     exception flags (plus s_ret), already qualified by valid
//   is_trap                 some event selected
//   is_int                  selected event is the interrupt
//   cause                   mcause value of the selected event
//   use_tval                mtval should carry the incoming tval
module trap_prio_enc
  import csr_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int INT_CAUSE_W = 4
) (
  input  logic                   int_acc,
  input  logic [INT_CAUSE_W-1:0] int_cause,
  input  logic [N_EXC-1:0]       exc,
  output logic                   is_trap,
  output logic                   is_int,
  output logic [XLEN-1:0]        cause,
  output logic                   use_tval
);

  always_comb begin
    is_trap  = 1'b1;
    is_int   = 1'b0;
    cause    = '0;
    use_tval = 1'b0;
    if (int_acc) begin
      is_int                   = 1'b1;
      cause[XLEN-1]            = 1'b1;
      cause[INT_CAUSE_W-1:0]   = int_cause;
    end else if (exc[EXC_INS_ADDR_MIS]) begin
      cause    = XLEN'(CAUSE_INS_ADDR_MIS);
      use_tval = 1'b1;
    end else if (exc[EXC_INS_PAGE_FAULT]) begin
      cause    = XLEN'(CAUSE_INS_PAGE_FAULT);
      use_tval = 1'b1;
    end else if (exc[EXC_INS_ACC_FAULT]) begin
      cause    = XLEN'(CAUSE_INS_ACC_FAULT);
      use_tval = 1'b1;
    end else if (exc[EXC_ILL_INS]) begin
      cause    = XLEN'(CAUSE_ILL_INS);
      use_tval = 1'b1;
    end else if (exc[EXC_S_RET]) begin
      // No S-mode: sret traps as an illegal instruction, but with mtval 0.
      cause    = XLEN'(CAUSE_ILL_INS);
    end else if (exc[EXC_ECALL]) begin
      cause    = XLEN'(CAUSE_ECALL_M);
    end else if (exc[EXC_EBREAK]) begin
      cause    = XLEN'(CAUSE_EBREAK);
    end else if (exc[EXC_ST_ADDR_MIS]) begin
      cause    = XLEN'(CAUSE_ST_ADDR_MIS);
      use_tval = 1'b1;
    end else if (exc[EXC_LD_ADDR_MIS]) begin
      cause    = XLEN'(CAUSE_LD_ADDR_MIS);
      use_tval = 1'b1;
    end else if (exc[EXC_ST_PAGE_FAULT]) begin
      cause    = XLEN'(CAUSE_ST_PAGE_FAULT);
      use_tval = 1'b1;
    end else if (exc[EXC_LD_PAGE_FAULT]) begin
      cause    = XLEN'(CAUSE_LD_PAGE_FAULT);
      use_tval = 1'b1;
    end else if (exc[EXC_ST_ACC_FAULT]) begin
      cause    = XLEN'(CAUSE_ST_ACC_FAULT);
      use_tval = 1'b1;
    end else if (exc[EXC_LD_ACC_FAULT]) begin
      cause    = XLEN'(CAUSE_LD_ACC_FAULT);
      use_tval = 1'b1;
    end else begin
      is_trap  = 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap entry / mret sequencer sitting between the commit stage and the
// machine-mode CSR file. Picks one event by priority, writes mepc, mcause,
// mtval, mstatus through the single CSR write port (one per cycle), then
// issues a one-cycle redirect + flush. mret writes mstatus then redirects.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid, pc, tval          commit-stage instruction and its fault value
//   <exception flags>, s_ret exception events (qualified by valid)
//   int_acc, int_cause       accepted interrupt (not qualified by valid)
//   m_ret                    machine return (lowest priority)
//   mtvec, mepc, mstatus     current CSR values
//   csr_write, csr_write_index, csr_data_w   CSR write port
//   busy                     pipeline stall request
//   flush, redirect, redirect_pc             one-cycle redirect
module trap_ctrl
  import csr_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int INT_CAUSE_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid,
  input  logic [XLEN-1:0]        pc,
  input  logic [XLEN-1:0]        tval,
  input  logic                   ins_addr_mis,
  input  logic                   ins_page_fault,
  input  logic                   ins_acc_fault,
  input  logic                   ill_ins,
  input  logic                   ecall,
  input  logic                   ebreak,
  input  logic                   st_addr_mis,
  input  logic                   ld_addr_mis,
  input  logic                   st_page_fault,
  input  logic                   ld_page_fault,
  input  logic                   st_acc_fault,
  input  logic                   ld_acc_fault,
  input  logic                   int_acc,
  input  logic [INT_CAUSE_W-1:0] int_cause,
  input  logic                   m_ret,
  input  logic                   s_ret,
  input  logic [XLEN-1:0]        mtvec,
  input  logic [XLEN-1:0]        mepc,
  input  logic [XLEN-1:0]        mstatus,
  output logic                   csr_write,
  output logic [11:0]            csr_write_index,
  output logic [XLEN-1:0]        csr_data_w,
  output logic                   busy,
  output logic                   flush,
  output logic                   redirect,
  output logic [XLEN-1:0]        redirect_pc
);

  trap_state_e state_reg, state_next;

  logic [XLEN-1:0] epc_reg;
  logic [XLEN-1:0] cause_reg;
  logic [XLEN-1:0] tval_reg;
  logic            is_int_reg;
  logic [XLEN-1:0] target_reg;

  logic [N_EXC-1:0] exc_raw;
  logic [N_EXC-1:0] exc_gated;

  logic            is_trap;
  logic            is_int;
  logic [XLEN-1:0] cause;
  logic            use_tval;
  logic            mret_evt;

  logic [XLEN-1:0] stat_trap;
  logic [XLEN-1:0] stat_ret;
  logic [XLEN-1:0] trap_target;

  assign exc_raw = {ld_acc_fault, st_acc_fault, ld_page_fault, st_page_fault,
                    ld_addr_mis, st_addr_mis, ebreak, ecall, s_ret, ill_ins,
                    ins_acc_fault, ins_page_fault, ins_addr_mis};

  // Exceptions only count for a valid commit; interrupts bypass this gate.
  for (genvar gi = 0; gi < N_EXC; gi++) begin : g_gate
    assign exc_gated[gi] = exc_raw[gi] & valid;
  end

  trap_prio_enc #(
    .XLEN        (XLEN),
    .INT_CAUSE_W (INT_CAUSE_W)
  ) u_prio (
    .int_acc   (int_acc),
    .int_cause (int_cause),
    .exc       (exc_gated),
    .is_trap   (is_trap),
    .is_int    (is_int),
    .cause     (cause),
    .use_tval  (use_tval)
  );

  // mret is taken only when nothing else is pending.
  assign mret_evt = valid & m_ret & ~is_trap;

  always_comb begin
    stat_trap                                = mstatus;
    stat_trap[MSTATUS_MPIE]                  = mstatus[MSTATUS_MIE];
    stat_trap[MSTATUS_MIE]                   = 1'b0;
    stat_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  always_comb begin
    stat_ret                                 = mstatus;
    stat_ret[MSTATUS_MIE]                    = mstatus[MSTATUS_MPIE];
    stat_ret[MSTATUS_MPIE]                   = 1'b1;
    stat_ret[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
  end

  // Vectored mode only offsets interrupts; exceptions always go to the base.
  always_comb begin
    trap_target = mtvec & ~XLEN'(3);
    if (mtvec[1:0] == 2'b01 && is_int_reg) begin
      trap_target = (mtvec & ~XLEN'(3)) + (XLEN'(cause_reg[INT_CAUSE_W-1:0]) << 2);
    end
  end

  // State register and latched trap context.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      epc_reg    <= '0;
      cause_reg  <= '0;
      tval_reg   <= '0;
      is_int_reg <= 1'b0;
      target_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && is_trap) begin
        epc_reg    <= pc;
        cause_reg  <= cause;
        tval_reg   <= use_tval ? tval : '0;
        is_int_reg <= is_int;
      end
      if (state_reg == ST_W_STAT) begin
        target_reg <= trap_target;
      end
      if (state_reg == ST_R_STAT) begin
        target_reg <= mepc;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (is_trap) begin
          state_next = ST_W_EPC;
        end else if (mret_evt) begin
          state_next = ST_R_STAT;
        end
      end
      ST_W_EPC:    state_next = ST_W_CAUSE;
      ST_W_CAUSE:  state_next = ST_W_TVAL;
      ST_W_TVAL:   state_next = ST_W_STAT;
      ST_W_STAT:   state_next = ST_REDIRECT;
      ST_R_STAT:   state_next = ST_REDIRECT;
      ST_REDIRECT: state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    csr_write       = 1'b0;
    csr_write_index = '0;
    csr_data_w      = '0;
    busy            = 1'b1;
    flush           = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = '0;
    case (state_reg)
      ST_IDLE: begin
        busy = is_trap | mret_evt;
      end
      ST_W_EPC: begin
        csr_write       = 1'b1;
        csr_write_index = CSR_MEPC;
        csr_data_w      = epc_reg & ~XLEN'(3);
      end
      ST_W_CAUSE: begin
        csr_write       = 1'b1;
        csr_write_index = CSR_MCAUSE;
        csr_data_w      = cause_reg;
      end
      ST_W_TVAL: begin
        csr_write       = 1'b1;
        csr_write_index = CSR_MTVAL;
        csr_data_w      = tval_reg;
      end
      ST_W_STAT: begin
        csr_write       = 1'b1;
        csr_write_index = CSR_MSTATUS;
        csr_data_w      = stat_trap;
      end
      ST_R_STAT: begin
        csr_write       = 1'b1;
        csr_write_index = CSR_MSTATUS;
        csr_data_w      = stat_ret;
      end
      ST_REDIRECT: begin
        flush       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = target_reg;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: the stimulus process predicts CSR writes,
// redirects and per-cycle busy from the architectural rules and queues them;
// a negedge monitor pops and compares whatever the DUT presents.
module tb_trap_ctrl;
  localparam int XLEN = 32;
  // Priority order (highest first) of the flag vector ev, with mcause and mtval use.
  // 0 ins_addr_mis, 1 ins_page_fault, 2 ins_acc_fault, 3 ill_ins, 4 s_ret,
  // 5 ecall, 6 ebreak, 7 st_addr_mis, 8 ld_addr_mis, 9 st_page_fault,
  // 10 ld_page_fault, 11 st_acc_fault, 12 ld_acc_fault
  localparam int CODE   [13] = '{0, 12, 1, 2, 2, 11, 3, 6, 4, 15, 13, 7, 5};
  localparam bit USE_TV [13] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};

  logic            clk = 1'b0;
  logic            rst;
  logic            valid;
  logic [XLEN-1:0] pc, tval, mtvec, mepc, mstatus;
  logic [12:0]     ev;
  logic            int_acc;
  logic [3:0]      int_cause;
  logic            m_ret;

  logic            csr_write;
  logic [11:0]     csr_write_index;
  logic [XLEN-1:0] csr_data_w;
  logic            busy, flush, redirect;
  logic [XLEN-1:0] redirect_pc;

  trap_ctrl #(.XLEN(XLEN), .INT_CAUSE_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid           (valid),
    .pc              (pc),
    .tval            (tval),
    .ins_addr_mis    (ev[0]),
    .ins_page_fault  (ev[1]),
    .ins_acc_fault   (ev[2]),
    .ill_ins         (ev[3]),
    .ecall           (ev[5]),
    .ebreak          (ev[6]),
    .st_addr_mis     (ev[7]),
    .ld_addr_mis     (ev[8]),
    .st_page_fault   (ev[9]),
    .ld_page_fault   (ev[10]),
    .st_acc_fault    (ev[11]),
    .ld_acc_fault    (ev[12]),
    .int_acc         (int_acc),
    .int_cause       (int_cause),
    .m_ret           (m_ret),
    .s_ret           (ev[4]),
    .mtvec           (mtvec),
    .mepc            (mepc),
    .mstatus         (mstatus),
    .csr_write       (csr_write),
    .csr_write_index (csr_write_index),
    .csr_data_w      (csr_data_w),
    .busy            (busy),
    .flush           (flush),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [11:0] idx; logic [31:0] data; } wr_t;
  typedef struct { int cyc; logic [31:0] pc; } rd_t;
  typedef struct { int cyc; bit val; } bz_t;

  wr_t wq[$];
  rd_t rq[$];
  bz_t bq[$];

  int  free_at = 0;   // first cycle the model can accept a new event
  bit  mon_en  = 1'b0;
  bit  done    = 1'b0;
  int  checks  = 0;
  int  failures = 0;

  function automatic logic [31:0] trap_stat(input logic [31:0] ms);
    return (ms & ~32'h0000_1888) | ({31'b0, ms[3]} << 7) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] ret_stat(input logic [31:0] ms);
    return (ms & ~32'h0000_1888) | ({31'b0, ms[7]} << 3) | 32'h0000_1880;
  endfunction

  task automatic push_trap(input int n, input logic [31:0] cause,
                           input logic [31:0] tv, input bit is_int, input int code);
    logic [31:0] tgt;
    wq.push_back('{n + 1, 12'h341, pc & ~32'h3});
    wq.push_back('{n + 2, 12'h342, cause});
    wq.push_back('{n + 3, 12'h343, tv});
    wq.push_back('{n + 4, 12'h300, trap_stat(mstatus)});
    tgt = mtvec & ~32'h3;
    if (is_int && mtvec[1:0] == 2'b01) tgt = tgt + 32'(4 * code);
    rq.push_back('{n + 5, tgt});
    free_at = n + 6;
  endtask

  task automatic prune(input int n);
    wr_t tw[$];
    rd_t tr[$];
    foreach (wq[i]) if (wq[i].cyc <= n) tw.push_back(wq[i]);
    foreach (rq[i]) if (rq[i].cyc <= n) tr.push_back(rq[i]);
    wq = tw;
    rq = tr;
  endtask

  // Predict this cycle's behaviour from the current inputs, then advance.
  task automatic step();
    int n;
    int hit;
    bit acc;
    n   = cyc;
    acc = 1'b0;
    if (rst) begin
      bq.push_back('{n, n < free_at});
      prune(n);
      free_at = n + 1;
    end else if (n < free_at) begin
      bq.push_back('{n, 1'b1});
    end else begin
      hit = -1;
      for (int i = 0; i < 13; i++) if (valid && ev[i] && hit < 0) hit = i;
      if (int_acc) begin
        acc = 1'b1;
        push_trap(n, 32'h8000_0000 | 32'(int_cause), 32'h0, 1'b1, int'(int_cause));
      end else if (hit >= 0) begin
        acc = 1'b1;
        push_trap(n, 32'(CODE[hit]), USE_TV[hit] ? tval : 32'h0, 1'b0, 0);
      end else if (valid && m_ret) begin
        acc = 1'b1;
        wq.push_back('{n + 1, 12'h300, ret_stat(mstatus)});
        rq.push_back('{n + 2, mepc});
        free_at = n + 3;
      end
      bq.push_back('{n, acc});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    valid   = 1'b0;
    ev      = '0;
    int_acc = 1'b0;
    m_ret   = 1'b0;
  endtask

  // Monitor: the only process that compares and counts.
  wr_t w;
  rd_t r;
  bz_t b;
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (wq.size() != 0 || rq.size() != 0) begin
        failures++;
        $display("FAIL drain: pending writes=%0d redirects=%0d, required 0", wq.size(), rq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end else if (mon_en) begin
      checks++;
      if (bq.size() == 0) begin
        failures++;
        $display("FAIL busy_pred cyc=%0d: no prediction", cyc);
      end else begin
        b = bq.pop_front();
        if (b.cyc != cyc || busy !== b.val) begin
          failures++;
          $display("FAIL busy cyc=%0d: got %b, required %b", cyc, busy, b.val);
        end
      end

      if (csr_write === 1'b1) begin
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write cyc=%0d: idx=%h data=%h", cyc, csr_write_index, csr_data_w);
        end else begin
          w = wq.pop_front();
          if (w.cyc != cyc || csr_write_index !== w.idx || csr_data_w !== w.data)
          begin
            failures++;
            $display("FAIL csr_write cyc=%0d: got idx=%h data=%h, required cyc=%0d idx=%h data=%h",
                     cyc, csr_write_index, csr_data_w, w.cyc, w.idx, w.data);
          end
        end
      end else if (wq.size() != 0 && wq[0].cyc <= cyc) begin
        checks++;
        failures++;
        w = wq.pop_front();
        $display("FAIL missing_write cyc=%0d: csr_write=%b, required idx=%h data=%h",
                 cyc, csr_write, w.idx, w.data);
      end

      if (redirect === 1'b1) begin
        checks++;
        if (rq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_redirect cyc=%0d: pc=%h", cyc, redirect_pc);
        end else begin
          r = rq.pop_front();
          if (r.cyc != cyc || redirect_pc !== r.pc || flush !== 1'b1) begin
            failures++;
            $display("FAIL redirect cyc=%0d: got pc=%h flush=%b, required cyc=%0d pc=%h flush=1",
                     cyc, redirect_pc, flush, r.cyc, r.pc);
          end
        end
      end else if (flush !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL flush cyc=%0d: got %b without redirect, required 0", cyc, flush);
      end else if (rq.size() != 0 && rq[0].cyc <= cyc) begin
        checks++;
        failures++;
        r = rq.pop_front();
        $display("FAIL missing_redirect cyc=%0d: redirect=%b, required pc=%h", cyc, redirect, r.pc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  logic [31:0] rnd;
  initial begin
    rst = 1'b1;
    clear();
    pc = '0; tval = '0; mtvec = '0; mepc = '0; mstatus = '0; int_cause = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step(); step();
    rst = 1'b0;
    step();

    // ecall, direct mode
    mtvec = 32'h8000; mstatus = 32'h8; pc = 32'h100; tval = 32'h55;
    valid = 1'b1; ev[5] = 1'b1; step(); clear(); repeat (6) step();

    // ld_addr_mis with ill_ins: ill_ins wins
    pc = 32'h200; tval = 32'hDEAD; valid = 1'b1; ev[8] = 1'b1; ev[3] = 1'b1;
    step(); clear(); repeat (6) step();

    // interrupt without valid, vectored mtvec
    int_acc = 1'b1; int_cause = 4'd7; mtvec = 32'h8001; pc = 32'h120;
    step(); clear(); repeat (6) step();

    // mret
    mstatus = 32'h1880; mepc = 32'h204; valid = 1'b1; m_ret = 1'b1;
    step(); clear(); repeat (3) step();

    // exception flag with valid=0 is ignored
    ev[3] = 1'b1; ev[12] = 1'b1; step(); clear(); step();

    // reset during W_TVAL, then a normal ecall
    mtvec = 32'h8000; mstatus = 32'h8; pc = 32'h300;
    valid = 1'b1; ev[5] = 1'b1; step(); clear(); step(); step();
    rst = 1'b1; step(); rst = 1'b0; step();
    valid = 1'b1; ev[5] = 1'b1; pc = 32'h304; step(); clear(); repeat (6) step();

    // ebreak held while busy is ignored
    valid = 1'b1; ev[5] = 1'b1; pc = 32'h400; step();
    ev = '0; ev[6] = 1'b1; repeat (3) step();
    clear(); repeat (4) step();

    // randomized traffic, including back-to-back events and occasional reset
    for (int k = 0; k < 600; k++) begin
      if (cyc >= free_at) begin
        rnd     = $urandom;
        mtvec   = {rnd[31:2], 1'b0, rnd[0]};
        mstatus = $urandom;
        mepc    = $urandom;
      end
      pc        = $urandom;
      tval      = $urandom;
      valid     = ($urandom % 4) != 0;
      for (int i = 0; i < 13; i++) ev[i] = ($urandom % 12) == 0;
      int_acc   = ($urandom % 16) == 0;
      int_cause = 4'($urandom);
      m_ret     = ($urandom % 5) == 0;
      rst       = ($urandom % 90) == 0;
      if (rst) clear();
      step();
      rst = 1'b0;
    end

    clear();
    for (int k = 0; k < 20 && cyc < free_at; k++) step();
    step(); step();
    done = 1'b1;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequences trap entry and trap return for the GPU core's machine-mode CSR file.
- Each cycle, takes the exception/interrupt flags of the instruction at the commit point and picks one cause by fixed priority.
- Drives the CSR file's single write port over a fixed multi-cycle sequence: mepc, mcause, mtval, mstatus.
- Then issues a one-cycle PC redirect plus pipeline flush. Sits between the commit stage and the CSR file and holds the pipeline stalled while busy.

Parameters:
- XLEN, 32, data/address width.
- INT_CAUSE_W, 4, width of the incoming interrupt cause code.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- valid  in  1  commit-stage instruction valid
- pc  in  XLEN  PC of the commit-stage instruction
- tval  in  XLEN  faulting address or instruction bits for mtval
- ins_addr_mis, ins_page_fault, ins_acc_fault, ill_ins, ecall, ebreak, st_addr_mis, ld_addr_mis, st_page_fault, ld_page_fault, st_acc_fault, ld_acc_fault  in  1 each  exception flags
- int_acc  in  1  interrupt accepted
- int_cause  in  INT_CAUSE_W  interrupt code
- m_ret, s_ret  in  1  return instructions
- mtvec, mepc, mstatus  in  XLEN  current CSR values
- csr_write  out  1  CSR write strobe
- csr_write_index  out  12  CSR address
- csr_data_w  out  XLEN  write data
- busy  out  1  stall request to the pipeline
- flush  out  1  one-cycle pipeline flush
- redirect  out  1  one-cycle PC redirect valid
- redirect_pc  out  XLEN  redirect target

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0.
  - Latched cause, epc and tval registers 0.
  - Reset mid-sequence abandons the sequence; no further CSR writes occur.
- Event sampling:
  - Events are sampled only in IDLE and only when valid=1.
  - int_acc is sampled in IDLE regardless of valid.
- Priority, highest first (mcause value in brackets):
  - int_acc [bit31=1, code=int_cause]
  - ins_addr_mis[0], ins_page_fault[12], ins_acc_fault[1]
  - ill_ins[2], s_ret[2] (no S-mode; s_ret is treated as illegal)
  - ecall[11], ebreak[3]
  - st_addr_mis[6], ld_addr_mis[4], st_page_fault[15], ld_page_fault[13], st_acc_fault[7], ld_acc_fault[5]
  - m_ret has the lowest priority and is taken only when no other event is set.
- Trap entry:
  - On the sampling edge, latch epc=pc, cause, and mtval. mtval = tval for address/page/access faults and ill_ins, 0 for all others (including interrupts, ecall, ebreak, s_ret).
  - busy rises in the same cycle as the event (combinational from IDLE + event) and stays high until the REDIRECT state completes.
- Sequence, one CSR write per cycle; csr_write is asserted only in the W_* states:
  - W_EPC: index 0x341, data epc with bits[1:0] forced to 0.
  - W_CAUSE: index 0x342.
  - W_TVAL: index 0x343.
  - W_STAT: index 0x300, data = mstatus with MPIE(7)<=MIE(3), MIE(3)<=0, MPP(12:11)<=2'b11.
  - REDIRECT: flush=1, redirect=1, busy=1, then return to IDLE.
- Trap target:
  - If mtvec[1:0]==2'b01 and the cause is an interrupt: {mtvec[XLEN-1:2],2'b00} + 4*code.
  - Otherwise: {mtvec[XLEN-1:2],2'b00}.
  - mtvec is sampled in W_STAT.
- Return path (m_ret only):
  - IDLE -> R_STAT: write 0x300 with MIE<=MPIE, MPIE<=1, MPP<=2'b11.
  - R_STAT -> REDIRECT: target = mepc sampled in R_STAT.
- Latency: event to redirect is 5 cycles for trap entry and 2 cycles for m_ret.
- Boundary cases:
  - Multiple flags set: only the highest-priority event is recorded.
  - Events arriving while busy are ignored. The pipeline is stalled, so flags are re-presented after the flush if still valid.
  - valid=0 with an exception flag set: flag ignored.
  - Back-to-back traps: a new event may be accepted in the cycle after REDIRECT (IDLE).

Decomposition:
- Shared package csr_pkg holds:
  - CSR address constants (MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343).
  - mstatus bit positions (MIE 3, MPIE 7, MPP 12:11).
  - Exception cause codes.
  - The FSM state enum.
- One natural sub-module: trap_prio_enc, a combinational priority encoder producing {is_trap, is_int, cause[XLEN-1:0], use_tval}.

Test Plan:
- ecall with valid=1, pc=0x100, mtvec=0x8000, mstatus=0x8:
  - writes 0x341<-0x100, 0x342<-11, 0x343<-0, 0x300<-0x1880 on cycles 1-4.
  - redirect_pc=0x8000 with flush on cycle 5; busy high for cycles 0-5.
- Simultaneous ld_addr_mis and ill_ins, tval=0xDEAD:
  - mcause=2, mtval=0xDEAD.
- int_acc with int_cause=7, valid=0, mtvec=0x8001:
  - mcause=0x80000007, redirect_pc=0x801C.
- m_ret with mstatus=0x1880, mepc=0x204:
  - cycle 1 writes 0x300<-0x1888.
  - cycle 2 redirect_pc=0x204; no writes to 0x341-0x343.
- rst asserted during W_TVAL:
  - the next cycle has no csr_write, busy=0, flush=0.
  - a subsequent ecall completes a normal sequence.
- ebreak asserted while busy (mid-sequence):
  - ignored; mcause keeps the original cause.
  - exactly 4 CSR writes and one redirect.
